sipo_deframer: RTL and testbench
================================

Name: sipo_deframer

Overview:
- Downstream partner of the PISO serializer. Consumes its serial OUT stream and reassembles WIDTH-bit parallel words.
- Each completed word is presented on a valid/ready output port.
- Supports bit-enable gaps, explicit frame resync and overrun detection.
- Sits between the serial link and any parallel consumer (register file, FIFO, checker).

Parameters:
- WIDTH, 4, data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in DOUT[WIDTH-1]; 0 = first bit lands in DOUT[0].

Ports:
- CLK  input  1  single system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- SIN  input  1  serial data bit, driven by the PISO OUT.
- SEN  input  1  bit-valid; SIN is sampled only on edges where SEN=1.
- SYNC  input  1  frame restart; discards any partial word.
- DREADY  input  1  consumer accepts DOUT on an edge where DVALID=1 and DREADY=1.
- DOUT  output  WIDTH  assembled word, registered.
- DVALID  output  1  DOUT holds an unconsumed word.
- BUSY  output  1  partial frame in progress (bit count != 0).
- OVR  output  1  sticky overrun flag.

Behaviour:
- Clocking and reset: one clock, CLK; reset RST is synchronous, active-high.
- Reset: with RST=1 at an edge, every output and internal state clears.
  - DOUT=0, DVALID=0, BUSY=0, OVR=0.
  - Bit counter=0, shift register=0.
  - RST overrides all other inputs and aborts a word in progress.
- Shifting: on an edge with SEN=1, SIN enters the shift register and the bit counter increments.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - SEN=0: shift register and counter hold.
- Frame completion: an edge with SEN=1 and counter=FRAME_LEN-1 completes the frame. FRAME_LEN=WIDTH, or WIDTH+1 when parity is enabled.
  - Counter returns to 0.
  - If the output is free, the word including the current bit loads into DOUT and DVALID=1 from that edge onward.
  - Latency: DVALID rises at the same edge that samples the last data bit, so it is visible in the following cycle.
- Output handshake:
  - DOUT is stable while DVALID=1.
  - An edge with DVALID=1 and DREADY=1 consumes the word, so DVALID=0 next cycle unless a new word loads at the same edge.
  - DOUT keeps its last value after consumption.
- Output free: the output is free when DVALID=0, or when DVALID=1 and DREADY=1 at the same edge.
  - Consume plus complete at the same edge: the new word loads, DVALID stays 1, no overrun.
- Overrun: a frame completes while DVALID=1 and DREADY=0.
  - The new word is dropped and DOUT keeps the old word.
  - OVR becomes 1 and stays set until RST.
- SYNC, with SEN=1: the current SIN becomes bit 0 of a new frame and the counter becomes 1. This holds even if the old frame would otherwise have completed on that edge.
- SYNC, with SEN=0: the counter becomes 0.
- SYNC never affects DOUT, DVALID or OVR.
- BUSY=1 exactly when counter != 0 (registered).

Optional Feature:
- Macro: SIPO_PARITY_CHK_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit (XOR of data bits and parity bit must be 0).
  - Extra output port PERR (1 bit), reset 0, loads together with DOUT.
  - PERR=1 marks a parity mismatch; the word is still delivered.
  - A dropped (overrun) word does not update PERR.
- Undefined: frame is WIDTH bits, no PERR port, no parity logic.

Test Plan (WIDTH=4, MSB_FIRST=1 unless stated):
- Reset: RST=1 for 2 edges mid-stream -> DOUT=0000, DVALID=0, BUSY=0, OVR=0; after release a fresh 1,0,1,1 yields DOUT=1011.
- Basic receive: SEN=1 continuous, SIN=1,0,1,1, DREADY=1 -> BUSY=1 after bits 1-3; DVALID=1 with DOUT=1011 one cycle after bit 4; DVALID=0 the following cycle.
- Bit order and gaps: MSB_FIRST=0, SIN=1,0,1,1 with SEN=0 for 2 cycles between bits -> DOUT=1101, with no extra latency beyond the last SEN edge.
- Backpressure and overrun: DREADY=0; send 1011 then 0110 -> DOUT stays 1011, OVR=1 after bit 8. Raise DREADY -> DVALID=0, OVR remains 1 until RST.
- Simultaneous consume and complete: DVALID=1 holding 1011; DREADY=1 on the same edge as the last bit of 0110 -> DOUT=0110, DVALID stays 1, OVR=0.
- SYNC mid-word: send 1,0, then SYNC=1 with SIN=0, then 1,1,0 -> DOUT=0110. With SIN=1101 and SIN=0 parity: macro on -> PERR=1 with DOUT=1101; parity bit 1 -> PERR=0.

Source files
------------

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: assembles WIDTH-bit words from a gated serial stream
// and presents them on a valid/ready port with sticky overrun. Optional macro: SIPO_PARITY_CHK_EN.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIN,
  input  logic             SEN,
  input  logic             SYNC,
  input  logic             DREADY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             BUSY,
`ifdef SIPO_PARITY_CHK_EN
  output logic             PERR,
`endif
  output logic             OVR
);

`ifdef SIPO_PARITY_CHK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             is_last;
  logic             complete;
  logic             out_free;
`ifdef SIPO_PARITY_CHK_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  always_comb begin
    if (MSB_FIRST != 0) shifted = {sh_q[WIDTH-2:0], SIN};
    else                shifted = {SIN, sh_q[WIDTH-1:1]};
    is_last  = (cnt_q == LAST_CNT);
    // SYNC wins over a frame that would otherwise complete on this edge.
    complete = SEN && !SYNC && is_last;
    out_free = !dvalid_q || DREADY;
`ifdef SIPO_PARITY_CHK_EN
    // The final bit is parity, so the data word is already complete in sh_q.
    word     = sh_q;
`else
    word     = shifted;
`endif

    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q;
`ifdef SIPO_PARITY_CHK_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif

    if (SEN) begin
      if (SYNC) begin
        sh_d  = shifted;
        cnt_d = CW'(1);
`ifdef SIPO_PARITY_CHK_EN
        par_d = SIN;
`endif
      end else if (is_last) begin
        sh_d  = word;
        cnt_d = '0;
`ifdef SIPO_PARITY_CHK_EN
        par_d = 1'b0;
`endif
      end else begin
        sh_d  = shifted;
        cnt_d = cnt_q + CW'(1);
`ifdef SIPO_PARITY_CHK_EN
        par_d = par_q ^ SIN;
`endif
      end
    end else if (SYNC) begin
      cnt_d = '0;
`ifdef SIPO_PARITY_CHK_EN
      par_d = 1'b0;
`endif
    end

    if (dvalid_q && DREADY) dvalid_d = 1'b0;
    if (complete) begin
      if (out_free) begin
        dout_d   = word;
        dvalid_d = 1'b1;
`ifdef SIPO_PARITY_CHK_EN
        perr_d   = par_q ^ SIN;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SIPO_PARITY_CHK_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
`ifdef SIPO_PARITY_CHK_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign BUSY   = busy_q;
  assign OVR    = ovr_q;
`ifdef SIPO_PARITY_CHK_EN
  assign PERR   = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed frames, expected words queued at issue time and
// checked by a negedge monitor on every accepted DOUT.
module tb_sipo_deframer;
  localparam int W = 4;
`ifdef SIPO_PARITY_CHK_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sin, sen, sync, dready;
  logic [W-1:0] dout;
  logic dvalid, busy, ovr, perr;
  logic l_sin, l_sen, l_dready;
  logic [W-1:0] l_dout;
  logic l_dvalid, l_busy, l_ovr, l_perr;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .CLK(clk), .RST(rst), .SIN(sin), .SEN(sen), .SYNC(sync), .DREADY(dready),
    .DOUT(dout), .DVALID(dvalid), .BUSY(busy),
`ifdef SIPO_PARITY_CHK_EN
    .PERR(perr),
`endif
    .OVR(ovr)
  );

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .CLK(clk), .RST(rst), .SIN(l_sin), .SEN(l_sen), .SYNC(1'b0), .DREADY(l_dready),
    .DOUT(l_dout), .DVALID(l_dvalid), .BUSY(l_busy),
`ifdef SIPO_PARITY_CHK_EN
    .PERR(l_perr),
`endif
    .OVR(l_ovr)
  );

`ifndef SIPO_PARITY_CHK_EN
  assign perr   = 1'b0;
  assign l_perr = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted word is compared against the head of the queue.
  always @(negedge clk) begin
    if (!rst && dvalid && dready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", {perr, dout}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("word", {27'd0, perr, dout}, {27'd0, mon_exp});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sen = 1'b1;
    step();
    sen = 1'b0;
    sin = 1'b0;
  endtask

  task automatic send_nib(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
`ifdef SIPO_PARITY_CHK_EN
    send_bit(^w);
`endif
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sen = 1'b0; sync = 1'b0; dready = 1'b1;
    l_sin = 1'b0; l_sen = 1'b0; l_dready = 1'b0;
    step(); step();
    chk("rst_dout", {28'd0, dout}, 32'h0);
    chk("rst_dvalid", {31'd0, dvalid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_ovr", {31'd0, ovr}, 32'h0);
    rst = 1'b0;
    step();

    // Basic receive 1011 with the consumer ready.
    exp_q.push_back({1'b0, 4'b1011});
    send_bit(1'b1); chk("busy_b1", {31'd0, busy}, 32'h1);
    send_bit(1'b0); chk("busy_b2", {31'd0, busy}, 32'h1);
    send_bit(1'b1); chk("busy_b3", {31'd0, busy}, 32'h1);
    chk("dvalid_early", {31'd0, dvalid}, 32'h0);
    send_bit(1'b1);
`ifdef SIPO_PARITY_CHK_EN
    send_bit(1'b1);
`endif
    chk("basic_dvalid", {31'd0, dvalid}, 32'h1);
    chk("basic_dout", {28'd0, dout}, 32'hb);
    chk("basic_busy", {31'd0, busy}, 32'h0);
    step();
    chk("basic_consumed", {31'd0, dvalid}, 32'h0);

    // Backpressure: second word is dropped and OVR sticks.
    dready = 1'b0;
    exp_q.push_back({1'b0, 4'b1011});
    send_nib(4'b1011);
    chk("bp_dvalid", {31'd0, dvalid}, 32'h1);
    chk("bp_ovr0", {31'd0, ovr}, 32'h0);
    send_nib(4'b0110);
    chk("ovr_dout", {28'd0, dout}, 32'hb);
    chk("ovr_set", {31'd0, ovr}, 32'h1);
    dready = 1'b1;
    step();
    chk("ovr_drain", {31'd0, dvalid}, 32'h0);
    chk("ovr_sticky", {31'd0, ovr}, 32'h1);
    step();
    chk("ovr_sticky2", {31'd0, ovr}, 32'h1);

    // Reset mid-stream clears everything; a fresh frame still works.
    send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst2_dout", {28'd0, dout}, 32'h0);
    chk("rst2_dvalid", {31'd0, dvalid}, 32'h0);
    chk("rst2_busy", {31'd0, busy}, 32'h0);
    chk("rst2_ovr", {31'd0, ovr}, 32'h0);
    exp_q.push_back({1'b0, 4'b1011});
    send_nib(4'b1011);
    chk("rst2_fresh", {28'd0, dout}, 32'hb);
    step();

    // Consume and complete on the same edge.
    dready = 1'b0;
    exp_q.push_back({1'b0, 4'b1011});
    send_nib(4'b1011);
    exp_q.push_back({1'b0, 4'b0110});
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef SIPO_PARITY_CHK_EN
    send_bit(1'b0);
`endif
    dready = 1'b1;
    send_bit(1'b0);
    chk("cc_dout", {28'd0, dout}, 32'h6);
    chk("cc_dvalid", {31'd0, dvalid}, 32'h1);
    chk("cc_ovr", {31'd0, ovr}, 32'h0);
    step();

    // SYNC with SEN=1 mid-word: SIN becomes bit 0 of a new frame.
    exp_q.push_back({1'b0, 4'b0110});
    send_bit(1'b1); send_bit(1'b0);
    sync = 1'b1; send_bit(1'b0); sync = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
`ifdef SIPO_PARITY_CHK_EN
    send_bit(1'b0);
`endif
    chk("sync_dout", {28'd0, dout}, 32'h6);
    step();

    // SYNC with SEN=0 returns the counter to idle.
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1; step(); sync = 1'b0;
    chk("sync_idle_busy", {31'd0, busy}, 32'h0);
    exp_q.push_back({1'b0, 4'b1001});
    send_nib(4'b1001);

    // SYNC on the edge that would have completed the frame.
    exp_q.push_back({1'b0, 4'b1001});
    for (int i = 0; i < FL - 1; i++) send_bit(1'b1);
    sync = 1'b1; send_bit(1'b1); sync = 1'b0;
    chk("sync_last_dvalid", {31'd0, dvalid}, 32'h0);
    chk("sync_last_busy", {31'd0, busy}, 32'h1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
`ifdef SIPO_PARITY_CHK_EN
    send_bit(1'b0);
`endif
    chk("sync_last_dout", {28'd0, dout}, 32'h9);
    step();

`ifdef SIPO_PARITY_CHK_EN
    exp_q.push_back({1'b1, 4'b1101});
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("perr_bad", {31'd0, perr}, 32'h1);
    exp_q.push_back({1'b0, 4'b1101});
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("perr_good", {31'd0, perr}, 32'h0);
    step();
`endif

    // LSB-first with two idle cycles between bits.
    for (int i = 0; i < 4; i++) begin
      l_sin = (i == 1) ? 1'b0 : 1'b1;
`ifndef SIPO_PARITY_CHK_EN
      if (i == 3) chk("lsb_not_early", {31'd0, l_dvalid}, 32'h0);
`endif
      l_sen = 1'b1; step(); l_sen = 1'b0;
      if (i != 3) begin step(); step(); end
    end
`ifdef SIPO_PARITY_CHK_EN
    step(); step();
    chk("lsb_not_early", {31'd0, l_dvalid}, 32'h0);
    l_sin = 1'b1; l_sen = 1'b1; step(); l_sen = 1'b0;
`endif
    chk("lsb_dvalid", {31'd0, l_dvalid}, 32'h1);
    chk("lsb_dout", {28'd0, l_dout}, 32'hd);
    chk("lsb_perr", {31'd0, l_perr}, 32'h0);

    step(); step(); step();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
